// File: rtl/adc_pattern_pkg.sv
// Shared constants for the ADC test-pattern generator:
// pattern mode encoding and Galois LFSR tap masks.
package adc_pattern_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_RAMP  = 2'd0;
    localparam mode_t MODE_CONST = 2'd1;
    localparam mode_t MODE_LFSR  = 2'd2;
    localparam mode_t MODE_WALK1 = 2'd3;

    // Right-shift Galois masks for maximal-length sequences
    function automatic logic [15:0] lfsr_mask(input int dw);
        case (dw)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/adc_pattern_if.sv
// Control and sample bus of the ADC pattern generator.
// master drives run controls, slave returns samples.
interface adc_pattern_if
    import adc_pattern_pkg::*;
#(
    parameter int NCH = 3,
    parameter int DW  = 8
);
    logic              en;
    mode_t             mode;
    logic [DW-1:0]     seed;
    logic [NCH*DW-1:0] adc_data;
    logic              adc_clk;
    logic              sample_valid;
    logic [31:0]       sample_cnt;

    modport master (
        output en, mode, seed,
        input  adc_data, adc_clk, sample_valid, sample_cnt
    );

    modport slave (
        input  en, mode, seed,
        output adc_data, adc_clk, sample_valid, sample_cnt
    );
endinterface

// File: rtl/adc_chan_gen.sv
// Next-value logic for one ADC channel; purely combinational.
// The channel index selects the ramp step and walking-one seed bit.
module adc_chan_gen
    import adc_pattern_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] cur,
    input  mode_t         mode,
    input  logic [DW-1:0] seed,
    input  logic [2:0]    chan,
    output logic [DW-1:0] next
);
    localparam logic [15:0]   MASK16 = lfsr_mask(DW);
    localparam logic [DW-1:0] MASK   = MASK16[DW-1:0];
    localparam logic [DW-1:0] ONE    = DW'(1);

    logic [DW-1:0] onehot;
    logic [DW-1:0] seed_k;
    logic [DW-1:0] lfsr_step;
    logic          zero;

    always_comb begin
        onehot    = ONE << (int'(chan) % DW);
        seed_k    = (seed ^ DW'(chan)) | ONE;
        lfsr_step = (cur >> 1) ^ (cur[0] ? MASK : '0);
        zero      = (cur == '0);
        next      = cur;
        unique case (1'b1)
            mode == MODE_RAMP:  next = cur + onehot;
            mode == MODE_CONST: next = seed;
            // An all-zero LFSR would lock up, so reseed it
            mode == MODE_LFSR:  next = zero ? seed_k : lfsr_step;
            mode == MODE_WALK1:
                next = zero ? onehot : {cur[DW-2:0], cur[DW-1]};
            default:            next = cur;
        endcase
    end
endmodule

// File: rtl/adc_pattern_gen.sv
// Multi-channel ADC test-pattern source with a divided sample
// clock; data updates once per DIV cycles while enabled.
module adc_pattern_gen
    import adc_pattern_pkg::*;
#(
    parameter int NCH = 3,
    parameter int DW  = 8,
    parameter int DIV = 4
) (
    input logic          USER_CLOCK,
    input logic          RESET,
    adc_pattern_if.slave bus
);
    if (NCH < 1 || NCH > 8 || DW < 4 || DW > 16 ||
        DIV < 2 || (DIV % 2) != 0) begin : g_param_err
        $error("adc_pattern_gen: NCH/DW/DIV out of range");
    end

    localparam int CW = $clog2(DIV);

    logic [CW-1:0]     div_cnt;
    logic              tick;
    logic              clk_q;
    logic              valid_q;
    logic [31:0]       cnt_q;
    logic [NCH*DW-1:0] data_q;
    logic [NCH*DW-1:0] data_nxt;

    assign tick = bus.en && (div_cnt == CW'(DIV - 1));

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        adc_chan_gen #(
            .DW (DW)
        ) u_chan (
            .cur  (data_q[k*DW +: DW]),
            .mode (bus.mode),
            .seed (bus.seed),
            .chan (3'(k)),
            .next (data_nxt[k*DW +: DW])
        );
    end

    always_ff @(posedge USER_CLOCK) begin
        if (RESET) begin
            div_cnt <= '0;
            clk_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else if (!bus.en) begin
            div_cnt <= '0;
            clk_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            // adc_clk trails div_cnt by one cycle to stay registered
            clk_q   <= (div_cnt < CW'(DIV / 2));
            valid_q <= tick;
            div_cnt <= tick ? '0 : div_cnt + CW'(1);
            if (tick) begin
                data_q <= data_nxt;
                cnt_q  <= cnt_q + 32'd1;
            end
        end
    end

    assign bus.adc_data     = data_q;
    assign bus.adc_clk      = clk_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_cnt   = cnt_q;
endmodule

// File: doc/adc_pattern_gen.md
ADC_PATTERN_GEN -- requirements
Module: adc_pattern_gen

Interface
REQ-001 Parameter NCH, default 3: number of ADC channels, 1..8.
REQ-002 Parameter DW, default 8: bits per channel, 4..16.
REQ-003 Parameter DIV, default 4: USER_CLOCK cycles per sample; even; DIV >= 2.
REQ-004 USER_CLOCK  in  1  sole clock; all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 en  in  1  run enable; sampled every cycle.
REQ-007 mode  in  2  pattern select: 0 RAMP, 1 CONST, 2 LFSR, 3 WALK1.
REQ-008 seed  in  DW  CONST value and LFSR seed.
REQ-009 adc_data  out  NCH*DW  channel k in bits [k*DW +: DW]; registered.
REQ-010 adc_clk  out  1  sample clock, period DIV cycles, 50% duty; registered.
REQ-011 sample_valid  out  1  one-cycle pulse in the cycle adc_data changes.
REQ-012 sample_cnt  out  32  number of updates since reset; wraps 2^32-1 -> 0.

Function
REQ-013 Divider counter div_cnt SHALL count 0..DIV-1 while en=1, wrap to 0, and hold at 0 while en=0.
REQ-014 adc_clk SHALL be 1 when en=1 and div_cnt < DIV/2; otherwise 0.
REQ-015 Update tick SHALL occur in the cycle where en=1 and div_cnt = DIV-1; the new adc_data, sample_valid=1 and sample_cnt+1 appear in the following cycle.
REQ-016 mode and seed SHALL be sampled only at the update tick; changes between ticks have no effect until the next tick.
REQ-017 RAMP: channel k += 2^(k mod DW) per tick, modulo 2^DW; from reset the first tick yields 1,2,4,... and the second 2,4,8,...
REQ-018 CONST: every channel SHALL load seed at each tick.
REQ-019 LFSR: each channel SHALL be an independent Galois LFSR using the DW-width tap mask from the package, advanced once per tick.
REQ-020 LFSR: if a channel's state is all-zero at a tick, it SHALL load (seed XOR k) with bit 0 forced to 1 instead of shifting.
REQ-021 WALK1: each channel SHALL rotate left by 1 per tick; an all-zero channel SHALL load one-hot bit (k mod DW).
REQ-022 A mode change SHALL take effect from the current adc_data value with no intermediate clear.
REQ-023 Deasserting en SHALL freeze adc_data and sample_cnt, force adc_clk=0 and sample_valid=0 from the next cycle, and leave no pending tick.
REQ-024 Reasserting en SHALL restart at div_cnt=0, so the first tick comes DIV cycles later.
REQ-025 sample_valid SHALL never be high in two consecutive cycles.

Reset
REQ-026 RESET=1 SHALL set adc_data=0, adc_clk=0, sample_valid=0, sample_cnt=0, and div_cnt=0 on the next clock edge.
REQ-027 RESET SHALL take priority over en, mode and any tick in the same cycle.
REQ-028 RESET asserted mid-period SHALL discard the partial period; no update SHALL follow it.

Structure
REQ-029 Package adc_pattern_pkg SHALL hold the mode encoding constants and the LFSR tap-mask table for DW 4..16; DW=8 uses mask 0xB8.
REQ-030 One sub-module, adc_chan_gen, SHALL produce the next value for one channel (inputs: current value, mode, seed, channel index); it is instantiated NCH times by generate.
REQ-031 An elaboration-time check SHALL reject NCH, DW and DIV values outside the ranges in REQ-001 to REQ-003.

Verification
REQ-032 Defaults; RESET for 16 cycles, then en=1, mode=RAMP -> adc_data ch0/1/2 = 1/2/4, 2/4/8, ... every 4 cycles; channel 2 wraps 252 -> 0; sample_valid pulses every 4th cycle.
REQ-033 mode=CONST, seed=0x5A, mode/seed changed mid-period -> all channels 0x5A only after the next tick; no change before it.
REQ-034 mode=LFSR from reset (all-zero state), seed=0x01 -> first tick loads 0x01/0x01/0x03; later ticks follow mask 0xB8; 255 ticks return each channel to its start value.
REQ-035 en pulsed low for 3 cycles mid-period -> adc_data and sample_cnt frozen, adc_clk=0; the next tick arrives exactly 4 cycles after en returns high.
REQ-036 RESET asserted on a tick cycle -> all outputs 0 next cycle, no sample_valid; with NCH=8, DW=12, DIV=6, RAMP -> ch7 step 128, adc_clk high 3 and low 3 cycles.
REQ-037 sample_cnt forced near 2^32-1 via a bench hook -> wraps to 0 on the next tick.
